dm_wb_cache: RTL and testbench

//  Responder for the CPU-side memory interface (mem_read/mem_write/mem_byte_enable)

---
 rtl/dm_wb_cache.sv | 138 +++++++++++++
 tb/tb_dm_wb_cache.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_wb_cache.sv
// Direct-mapped, write-back, write-allocate cache with 16-byte lines.
// CPU sees a 16-bit word port; misses move whole lines over the pmem port.
module dm_wb_cache #(
  parameter int unsigned INDEX_BITS = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [15:0]   mem_address,
  input  logic          mem_read,
  input  logic          mem_write,
  input  logic [1:0]    mem_byte_enable,
  input  logic [15:0]   mem_wdata,
  output logic [15:0]   mem_rdata,
  output logic          mem_resp,
  output logic [15:0]   pmem_address,
  output logic          pmem_read,
  output logic          pmem_write,
  output logic [127:0]  pmem_wdata,
  input  logic [127:0]  pmem_rdata,
  input  logic          pmem_resp
);

  localparam int unsigned TagBits = 12 - INDEX_BITS;
  localparam int unsigned Sets    = 1 << INDEX_BITS;

  typedef enum logic [1:0] {StCompare, StWriteback, StAllocate} state_e;

  state_e state_q, state_d;

  logic [Sets-1:0]    valid_q;
  logic [Sets-1:0]    dirty_q;
  logic [TagBits-1:0] tag_q  [Sets];
  logic [127:0]       data_q [Sets];

  // Miss address is latched so a request dropped mid-miss still installs its line.
  logic [TagBits-1:0]    miss_tag_q;
  logic [INDEX_BITS-1:0] miss_idx_q;

  logic [TagBits-1:0]    addr_tag;
  logic [INDEX_BITS-1:0] addr_idx;
  logic [2:0]            addr_word;
  logic                  unused_addr_bit0;

  logic         req, hit;
  logic         write_hit, miss_start, wb_done, fill;
  logic [127:0] line_wr;

  assign addr_tag         = mem_address[15:16-TagBits];
  assign addr_idx         = mem_address[3+INDEX_BITS:4];
  assign addr_word        = mem_address[3:1];
  assign unused_addr_bit0 = mem_address[0];

  assign req = mem_read | mem_write;
  assign hit = valid_q[addr_idx] && (tag_q[addr_idx] == addr_tag);

  assign mem_rdata  = data_q[addr_idx][{addr_word, 4'b0000} +: 16];
  assign pmem_wdata = data_q[miss_idx_q];

  always_comb begin
    line_wr = data_q[addr_idx];
    if (mem_byte_enable[0]) line_wr[{addr_word, 4'b0000} +: 8] = mem_wdata[7:0];
    if (mem_byte_enable[1]) line_wr[{addr_word, 4'b1000} +: 8] = mem_wdata[15:8];
  end

  always_comb begin
    state_d      = state_q;
    mem_resp     = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = 16'h0000;
    write_hit    = 1'b0;
    miss_start   = 1'b0;
    wb_done      = 1'b0;
    fill         = 1'b0;
    unique case (state_q)
      StCompare: begin
        if (req) begin
          if (hit) begin
            mem_resp  = 1'b1;
            write_hit = mem_write;
          end else begin
            miss_start = 1'b1;
            state_d    = (valid_q[addr_idx] && dirty_q[addr_idx]) ? StWriteback : StAllocate;
          end
        end
      end
      StWriteback: begin
        pmem_write   = 1'b1;
        pmem_address = {tag_q[miss_idx_q], miss_idx_q, 4'b0000};
        if (pmem_resp) begin
          wb_done = 1'b1;
          state_d = StAllocate;
        end
      end
      StAllocate: begin
        pmem_read    = 1'b1;
        pmem_address = {miss_tag_q, miss_idx_q, 4'b0000};
        if (pmem_resp) begin
          fill    = 1'b1;
          state_d = StCompare;
        end
      end
      default: state_d = StCompare;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StCompare;
      valid_q    <= '0;
      dirty_q    <= '0;
      miss_tag_q <= '0;
      miss_idx_q <= '0;
    end else begin
      state_q <= state_d;
      if (miss_start) begin
        miss_tag_q <= addr_tag;
        miss_idx_q <= addr_idx;
      end
      if (write_hit) dirty_q[addr_idx] <= 1'b1;
      if (wb_done) dirty_q[miss_idx_q] <= 1'b0;
      if (fill) begin
        valid_q[miss_idx_q] <= 1'b1;
        dirty_q[miss_idx_q] <= 1'b0;
      end
    end
  end

  // Tag and data arrays carry no reset; validity alone guards them.
  always_ff @(posedge clk) begin
    if (write_hit) data_q[addr_idx] <= line_wr;
    if (fill) begin
      data_q[miss_idx_q] <= pmem_rdata;
      tag_q[miss_idx_q]  <= miss_tag_q;
    end
  end

endmodule

// File: tb/tb_dm_wb_cache.sv
// Directed self-checking bench for dm_wb_cache.
module tb_dm_wb_cache;

  logic         clk;
  logic         rst_n;
  logic [15:0]  mem_address;
  logic         mem_read;
  logic         mem_write;
  logic [1:0]   mem_byte_enable;
  logic [15:0]  mem_wdata;
  logic [15:0]  mem_rdata;
  logic         mem_resp;
  logic [15:0]  pmem_address;
  logic         pmem_read;
  logic         pmem_write;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;

  int checks;
  int failures;

  dm_wb_cache #(.INDEX_BITS(3)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .mem_address     (mem_address),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_byte_enable (mem_byte_enable),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
    .mem_resp        (mem_resp),
    .pmem_address    (pmem_address),
    .pmem_read       (pmem_read),
    .pmem_write      (pmem_write),
    .pmem_wdata      (pmem_wdata),
    .pmem_rdata      (pmem_rdata),
    .pmem_resp       (pmem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  function automatic logic [127:0] make_line(input logic [15:0] base);
    logic [127:0] l;
    for (int w = 0; w < 8; w++) l[w*16 +: 16] = base + 16'(w);
    return l;
  endfunction

  function automatic logic [127:0] set_word(input logic [127:0] l, input int w,
                                            input logic [15:0] v);
    logic [127:0] r;
    r = l;
    r[w*16 +: 16] = v;
    return r;
  endfunction

  logic [127:0] line_a, line_b, line_c;

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    mem_address = 16'h0000;
    mem_read = 1'b0;
    mem_write = 1'b0;
    mem_byte_enable = 2'b00;
    mem_wdata = 16'h0000;
    pmem_rdata = '0;
    pmem_resp = 1'b0;
    line_a = set_word(make_line(16'h1000), 3, 16'hBEEF);
    line_b = make_line(16'h5000);
    line_c = make_line(16'hC000);

    #1;
    chk("rst_mem_resp", mem_resp, 0);
    chk("rst_pmem_read", pmem_read, 0);
    chk("rst_pmem_write", pmem_write, 0);
    chk("rst_pmem_address", pmem_address, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Cold read miss, fill, then hit on the retry cycle
    @(negedge clk);
    mem_read = 1'b1;
    mem_address = 16'h1236;
    #1;
    chk("t1_miss_no_resp", mem_resp, 0);
    chk("t1_compare_no_pread", pmem_read, 0);
    @(negedge clk); #1;
    chk("t1_alloc_pread", pmem_read, 1);
    chk("t1_alloc_pwrite", pmem_write, 0);
    chk("t1_alloc_addr", pmem_address, 16'h1230);
    chk("t1_alloc_no_resp", mem_resp, 0);
    pmem_rdata = line_a;
    pmem_resp = 1'b1;
    @(negedge clk);
    pmem_resp = 1'b0;
    #1;
    chk("t1_hit_resp", mem_resp, 1);
    chk("t1_hit_rdata", mem_rdata, 16'hBEEF);
    chk("t1_hit_pread", pmem_read, 0);

    // Read hit on another word
    @(negedge clk);
    mem_address = 16'h1230;
    #1;
    chk("t2_hit_resp", mem_resp, 1);
    chk("t2_hit_rdata", mem_rdata, 16'h1000);
    chk("t2_no_pread", pmem_read, 0);

    // Low-byte write hit, then readback
    @(negedge clk);
    mem_read = 1'b0;
    mem_write = 1'b1;
    mem_byte_enable = 2'b01;
    mem_wdata = 16'hAA55;
    mem_address = 16'h1232;
    #1;
    chk("t3_write_resp", mem_resp, 1);
    @(negedge clk);
    mem_write = 1'b0;
    mem_read = 1'b1;
    mem_byte_enable = 2'b00;
    #1;
    chk("t3_readback_resp", mem_resp, 1);
    chk("t3_readback_rdata", mem_rdata, 16'h1055);

    // Conflict miss on dirty line: writeback, allocate, hit
    @(negedge clk);
    mem_address = 16'h9232;
    #1;
    chk("t4_miss_no_resp", mem_resp, 0);
    @(negedge clk); #1;
    chk("t4_wb_pwrite", pmem_write, 1);
    chk("t4_wb_pread", pmem_read, 0);
    chk("t4_wb_addr", pmem_address, 16'h1230);
    chk("t4_wb_wdata", pmem_wdata, set_word(line_a, 1, 16'h1055));
    @(negedge clk); #1;
    chk("t4_wb_hold_pwrite", pmem_write, 1);
    chk("t4_wb_hold_addr", pmem_address, 16'h1230);
    pmem_resp = 1'b1;
    @(negedge clk);
    pmem_resp = 1'b0;
    #1;
    chk("t4_alloc_pread", pmem_read, 1);
    chk("t4_alloc_pwrite", pmem_write, 0);
    chk("t4_alloc_addr", pmem_address, 16'h9230);
    chk("t4_alloc_no_resp", mem_resp, 0);
    pmem_rdata = line_b;
    pmem_resp = 1'b1;
    @(negedge clk);
    pmem_resp = 1'b0;
    #1;
    chk("t4_hit_resp", mem_resp, 1);
    chk("t4_hit_rdata", mem_rdata, 16'h5001);

    // Reset during allocate abandons the fill and clears validity
    @(negedge clk);
    mem_address = 16'h1230;
    #1;
    chk("t5_miss_no_resp", mem_resp, 0);
    @(negedge clk); #1;
    chk("t5_clean_alloc_pread", pmem_read, 1);
    chk("t5_clean_no_pwrite", pmem_write, 0);
    chk("t5_alloc_addr", pmem_address, 16'h1230);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_pread", pmem_read, 0);
    chk("t5_rst_addr", pmem_address, 0);
    chk("t5_rst_no_resp", mem_resp, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("t5_after_rst_miss", mem_resp, 0);
    @(negedge clk); #1;
    chk("t5_realloc_pread", pmem_read, 1);
    chk("t5_realloc_addr", pmem_address, 16'h1230);

    // Request dropped mid-allocate: line still installed, no response
    mem_read = 1'b0;
    pmem_rdata = line_c;
    pmem_resp = 1'b1;
    @(negedge clk);
    pmem_resp = 1'b0;
    #1;
    chk("t6_dropped_no_resp", mem_resp, 0);
    chk("t6_dropped_pread", pmem_read, 0);
    @(negedge clk);
    mem_read = 1'b1;
    mem_address = 16'h1234;
    #1;
    chk("t6_later_hit_resp", mem_resp, 1);
    chk("t6_later_hit_rdata", mem_rdata, 16'hC002);

    // Read+write together acts as write; empty byte enable changes nothing
    @(negedge clk);
    mem_write = 1'b1;
    mem_byte_enable = 2'b00;
    mem_wdata = 16'hFFFF;
    #1;
    chk("t7_be0_resp", mem_resp, 1);
    @(negedge clk);
    mem_write = 1'b0;
    #1;
    chk("t7_be0_rdata", mem_rdata, 16'hC002);
    @(negedge clk);
    mem_write = 1'b1;
    mem_byte_enable = 2'b10;
    mem_wdata = 16'h77FF;
    #1;
    chk("t7_hi_resp", mem_resp, 1);
    @(negedge clk);
    mem_write = 1'b0;
    mem_byte_enable = 2'b00;
    #1;
    chk("t7_hi_rdata", mem_rdata, 16'h7702);

    // Stray pmem_resp in COMPARE is ignored
    @(negedge clk);
    mem_read = 1'b0;
    pmem_resp = 1'b1;
    #1;
    chk("t8_stray_no_resp", mem_resp, 0);
    chk("t8_stray_no_pread", pmem_read, 0);
    @(negedge clk);
    pmem_resp = 1'b0;
    #1;
    chk("t8_idle_pread", pmem_read, 0);
    chk("t8_idle_pwrite", pmem_write, 0);

    // Line dirtied by the high-byte write is written back on conflict
    mem_read = 1'b1;
    mem_address = 16'h9230;
    #1;
    chk("t9_miss_no_resp", mem_resp, 0);
    @(negedge clk); #1;
    chk("t9_wb_pwrite", pmem_write, 1);
    chk("t9_wb_addr", pmem_address, 16'h1230);
    chk("t9_wb_wdata", pmem_wdata, set_word(line_c, 2, 16'h7702));
    pmem_resp = 1'b1;
    @(negedge clk);
    pmem_resp = 1'b0;
    #1;
    chk("t9_alloc_pread", pmem_read, 1);
    chk("t9_alloc_addr", pmem_address, 16'h9230);
    pmem_rdata = line_b;
    pmem_resp = 1'b1;
    @(negedge clk);
    pmem_resp = 1'b0;
    #1;
    chk("t9_hit_resp", mem_resp, 1);
    chk("t9_hit_rdata", mem_rdata, 16'h5000);
    mem_read = 1'b0;

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
